// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed 7-segment scanner with blanking gaps
// and frame-synchronous double-buffered display updates.

module decode_7seg (
    input  logic [3:0] nib,
    output logic [7:1] seg
);
    always_comb begin
        seg = 7'b0000000;
        unique case (nib)
            4'h0: seg = 7'b1111110;
            4'h1: seg = 7'b0110000;
            4'h2: seg = 7'b1101101;
            4'h3: seg = 7'b1111001;
            4'h4: seg = 7'b0110011;
            4'h5: seg = 7'b1011011;
            4'h6: seg = 7'b1011111;
            4'h7: seg = 7'b1110000;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1111011;
            4'ha: seg = 7'b1110111;
            4'hb: seg = 7'b0011111;
            4'hc: seg = 7'b0001101;
            4'hd: seg = 7'b0111101;
            4'he: seg = 7'b1001111;
            4'hf: seg = 7'b1000111;
        endcase
    end
endmodule

module seg_scan_ctrl #(
    parameter int NDIG  = 8,
    parameter int DIV   = 50000,
    parameter int BLANK = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              lz_en,
    input  logic              wr_en,
    input  logic [4*NDIG-1:0] wr_data,
    input  logic [NDIG-1:0]   wr_dp,
    output logic [7:0]        seg_out,
    output logic [NDIG-1:0]   dig_en,
    output logic              frame_done,
    output logic              pending
);
    localparam int MAXC = (DIV > BLANK) ? DIV : BLANK;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic {S_BLANK, S_SHOW} state_t;

    state_t            state, state_nx;
    logic [IW-1:0]     idx, idx_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic [4*NDIG-1:0] disp, shadow;
    logic [NDIG-1:0]   disp_dp, shadow_dp;
    logic              boundary;
    logic              commit;
    logic [NDIG-1:0]   zero_up;
    logic [3:0]        nib;
    logic [7:1]        dec;
    logic              dp_bit;
    logic              sup;
    logic [7:0]        seg_nx;
    logic [NDIG-1:0]   dig_nx;

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt + 1'b1;
        boundary = 1'b0;
        if (!enable) begin
            state_nx = S_BLANK;
            idx_nx   = '0;
            cnt_nx   = '0;
        end else begin
            unique case (state)
                S_BLANK: begin
                    if (cnt == CW'(BLANK - 1)) begin
                        state_nx = S_SHOW;
                        cnt_nx   = '0;
                    end
                end
                S_SHOW: begin
                    if (cnt == CW'(DIV - 1)) begin
                        state_nx = S_BLANK;
                        cnt_nx   = '0;
                        boundary = (idx == IW'(NDIG - 1));
                        idx_nx   = boundary ? '0 : idx + 1'b1;
                    end
                end
            endcase
        end
    end

    // zero_up[i] is set when nibbles i..NDIG-1 are all zero
    always_comb begin
        logic z;
        z       = 1'b1;
        zero_up = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            z          = z && (disp[4*i +: 4] == 4'h0);
            zero_up[i] = z;
        end
    end

    always_comb begin
        nib    = 4'h0;
        dp_bit = 1'b0;
        sup    = 1'b0;
        dig_nx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx_nx == IW'(i)) begin
                nib       = disp[4*i +: 4];
                dp_bit    = disp_dp[i];
                sup       = lz_en && (i != 0) && zero_up[i];
                dig_nx[i] = (state_nx == S_SHOW);
            end
        end
    end

    decode_7seg u_dec (
        .nib (nib),
        .seg (dec)
    );

    always_comb begin
        seg_nx = 8'h00;
        if (state_nx == S_SHOW)
            seg_nx = {sup ? 7'h00 : dec, dp_bit};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_BLANK;
            idx        <= '0;
            cnt        <= '0;
            seg_out    <= 8'h00;
            dig_en     <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            idx        <= idx_nx;
            cnt        <= cnt_nx;
            seg_out    <= seg_nx;
            dig_en     <= dig_nx;
            frame_done <= boundary;
        end
    end

    // While idle there is no frame to protect, so updates land at once
    assign commit = boundary || !enable;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            disp      <= '0;
            disp_dp   <= '0;
            shadow    <= '0;
            shadow_dp <= '0;
            pending   <= 1'b0;
        end else if (wr_en) begin
            shadow    <= wr_data;
            shadow_dp <= wr_dp;
            pending   <= !commit;
            if (commit) begin
                disp    <= wr_data;
                disp_dp <= wr_dp;
            end
        end else if (pending && commit) begin
            disp    <= shadow;
            disp_dp <= shadow_dp;
            pending <= 1'b0;
        end
    end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a bank of common-select 7-segment digits. It holds a display word and steps one digit at a time through an internal decode_7seg instance. It drives the shared segment bus plus one digit-enable line per digit, inserting blanking gaps between digits to suppress ghosting. Display updates are double-buffered and committed only at frame boundaries, so a frame never shows a mix of old and new data.

Parameters:
NDIG, 8, number of digits; nibble i is wr_data[4*i+3:4*i]; digit 0 is least significant.
DIV, 50000, clock cycles each digit is lit per frame (>=1).
BLANK, 16, clock cycles of all-off between consecutive digits (>=1).

Ports:
clock  in  1  system clock, all state on rising edge.
reset  in  1  asynchronous, active-low reset.
enable  in  1  1 = scanning; 0 = forced dark and idle.
lz_en  in  1  leading-zero suppression enable; live, not latched.
wr_en  in  1  single-cycle write strobe.
wr_data  in  4*NDIG  new display nibbles.
wr_dp  in  NDIG  new decimal-point bits, one per digit.
seg_out  out  8  segments {a,b,c,d,e,f,g,dp}, active-high, bit7 = a, bit0 = dp.
dig_en  out  NDIG  one-hot active-high digit select; all-zero during blanking.
frame_done  out  1  one-cycle pulse at each frame boundary.
pending  out  1  shadow holds an uncommitted write.

Behaviour:
- Reset (async, reset=0) clears the following:
  - state = BLANK, idx = 0, cycle counter = 0.
  - disp, disp_dp, shadow and shadow_dp = 0.
  - pending = 0, seg_out = 0, dig_en = 0, frame_done = 0.
  - Reset asserted mid-frame aborts the frame immediately and drops any pending write.
- Registers:
  - shadow/shadow_dp hold the last write.
  - disp/disp_dp are the committed values used for display.
- Write: wr_en=1 loads shadow <= wr_data and shadow_dp <= wr_dp, and sets pending=1. Back-to-back writes overwrite; the last one wins.
- FSM, two states, with cnt as the cycle counter:
  - BLANK: seg_out=0, dig_en=0. Counts BLANK cycles, then moves to SHOW with cnt cleared.
  - SHOW: dig_en[idx]=1. seg_out[7:1] = decode_7seg(disp nibble idx)[7:1], and seg_out[0] = disp_dp[idx]. Counts DIV cycles, then moves to BLANK with idx <= (idx+1) mod NDIG.
- Outputs are registered and change on the same edge as the state. dig_en is therefore nonzero for exactly DIV cycles per digit. Frame period = NDIG*(DIV+BLANK) cycles.
- Frame boundary: the edge that leaves SHOW with idx = NDIG-1.
  - frame_done pulses for 1 cycle, aligned with the first BLANK cycle.
  - If pending=1, disp <= shadow, disp_dp <= shadow_dp, and pending <= 0.
  - If pending=0, disp is unchanged; frame_done still pulses.
- Write coinciding with the boundary edge: wr_data/wr_dp bypass shadow and are committed directly to disp. pending ends at 0.
- Leading-zero suppression, when lz_en=1:
  - Digit i (i >= 1) is suppressed if nibble i is 0 and all higher nibbles are 0.
  - A suppressed digit has seg_out[7:1]=0. dp is still driven and dig_en is still asserted.
  - Digit 0 is never suppressed.
- enable=0 takes effect on the next edge:
  - state=BLANK, idx=0, cnt=0, outputs 0, frame_done=0.
  - Writes are still accepted and commit immediately, so pending clears the cycle after wr_en.
  - When enable returns to 1, scanning restarts with a full BLANK before digit 0.
- decode_7seg patterns (bit7..bit1 significant):
  - 0=1111110x, 1=0110000x, 2=1101101x, 3=1111001x, 4=0110011x, 5=1011011x.
  - 6=1011111x, 7=1110000x, 8=1111111x, 9=1111011x, A=1110111x, b=0011111x.
  - c=0001101x, d=0111101x, E=1001111x, F=1000111x.

Test Plan:
All scenarios use NDIG=4, DIV=4, BLANK=2.
- Reset, enable=1, write 0x1234 / dp=4'b0000, wait one frame. Next frame shows the following (24-cycle period, each digit lit 4 cycles, 2 dark cycles between):
  - dig_en=0001, seg_out=01100110.
  - dig_en=0010, seg_out=11110010.
  - dig_en=0100, seg_out=11011010.
  - dig_en=1000, seg_out=01100000.
- Write 0x0050 with lz_en=1, dp=4'b0100 -> digit3 seg_out=00000000, digit2 seg_out=00000001, digit1 seg_out=10110110, digit0 seg_out=11111100. With lz_en=0, digit3 seg_out=11111100 instead.
- Write 0xABCD while digit 1 is lit -> pending=1, the rest of the frame still shows the old data. frame_done pulses; the next frame shows d,c,b,A, and pending=0.
- Assert wr_en on the exact frame-boundary edge with 0xFFFF -> next frame shows F on all digits, pending stays 0. Two writes within one frame -> only the second is displayed.
- Drop enable while digit 2 is lit -> dig_en=0 and seg_out=0 next cycle. Re-raise enable -> 2 BLANK cycles, then digit 0 for 4 cycles.
- Pull reset low mid-SHOW with a write pending -> all outputs 0 immediately, without waiting for a clock. After release with enable=1, the display shows 0 on all digits and pending=0.
